// File: rtl/number_display_pkg.sv
// number_display_pkg
//   Shared constants and helpers for the seven-segment number scanner.
//   - Segment patterns are {g,f,e,d,c,b,a}, active-low (0 lights a segment).
//   - slot_e names the four digit positions; slot 3 is the leftmost digit.
//   - group_of() extracts the 12-bit {hundreds, tens, ones} BCD group i
//     from the packed 48-bit bus.
package number_display_pkg;

    localparam int NUM_GROUPS = 4;
    localparam int GROUP_W    = 12;
    localparam int BUS_W      = NUM_GROUPS * GROUP_W;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ERR   = 7'b0000110;

    // Digit positions; the numeric value is also the an[] bit that goes low.
    typedef enum logic [1:0] {
        SLOT_ONES     = 2'd0,
        SLOT_TENS     = 2'd1,
        SLOT_HUNDREDS = 2'd2,
        SLOT_INDEX    = 2'd3
    } slot_e;

    // Group i lives at numbers[12i+11:12i].
    function automatic logic [GROUP_W-1:0] group_of(input logic [BUS_W-1:0] numbers,
                                                    input logic [1:0]       idx);
        logic [GROUP_W-1:0] g;
        g = numbers[11:0];
        case (idx)
            2'd0: g = numbers[11:0];
            2'd1: g = numbers[23:12];
            2'd2: g = numbers[35:24];
            2'd3: g = numbers[47:36];
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg
//   Combinational BCD digit to active-low seven-segment pattern.
//   Ports:
//     digit  in  4  BCD digit; values above 9 render as "E"
//     blank  in  1  force all segments off (leading-zero blanking)
//     seg    out 7  {g,f,e,d,c,b,a}, active-low
module bcd_to_seg
    import number_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: assign a default before any branch so every path drives seg
        // and no latch is inferred.
        seg = SEG_ERR;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_ERR;
            endcase
        end
    end

endmodule

// File: rtl/number_display_scanner.sv
// number_display_scanner
//   Snapshots four 3-digit BCD numbers plus a valid mask and scans them onto
//   a 4-digit common-anode seven-segment display. The leftmost digit shows
//   the number's index (1-4) with the decimal point lit; the right three show
//   the value with leading-zero blanking. The display dwells on each valid
//   number for DWELL_FRAMES full frames, then moves to the next valid one.
//   Ports:
//     clk      in  1   system clock
//     rst_n    in  1   synchronous active-low reset
//     numbers  in  48  four BCD groups, group i = numbers[12i+11:12i]
//     valid    in  4   valid[i]=1 when number i is in play
//     load     in  1   one-cycle strobe capturing numbers/valid
//     seg      out 7   {g,f,e,d,c,b,a}, active-low, registered
//     an       out 4   one-hot active-low digit enable, an[3] leftmost
//     dp       out 1   decimal point, active-low
//     sel      out 2   index of the number currently selected
module number_display_scanner
    import number_display_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int DWELL_FRAMES = 250
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BUS_W-1:0] numbers,
    input  logic [3:0]       valid,
    input  logic             load,
    output logic [6:0]       seg,
    output logic [3:0]       an,
    output logic             dp,
    output logic [1:0]       sel
);

    localparam int REFRESH_W = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
    localparam int FRAME_W   = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_DIV - 1);
    localparam logic [FRAME_W-1:0]   FRAME_LAST   = FRAME_W'(DWELL_FRAMES - 1);

    logic [REFRESH_W-1:0] refresh_q;
    slot_e                slot_q;
    logic [FRAME_W-1:0]   frame_q;
    logic [1:0]           sel_q;
    logic [BUS_W-1:0]     num_q;
    logic [3:0]           valid_q;

    logic                 slot_wrap;
    logic                 frame_wrap;
    logic [1:0]           next_sel;
    logic [1:0]           load_sel;

    assign slot_wrap  = (refresh_q == REFRESH_LAST);
    assign frame_wrap = slot_wrap && (slot_q == SLOT_INDEX);
    assign sel        = sel_q;

    // Next valid index in circular order sel+1, sel+2, sel+3, sel. With no
    // valid bits the current selection is kept.
    always_comb begin
        logic       found;
        logic [1:0] cand;
        next_sel = sel_q;
        found    = 1'b0;
        cand     = sel_q;
        for (int k = 1; k <= NUM_GROUPS; k++) begin
            cand = sel_q + 2'(k);
            if (!found && valid_q[cand]) begin
                next_sel = cand;
                found    = 1'b1;
            end
        end
    end

    // Lowest set bit of the incoming valid mask; 0 when none are set.
    always_comb begin
        load_sel = 2'd0;
        for (int i = NUM_GROUPS - 1; i >= 0; i--) begin
            if (valid[i]) begin
                load_sel = 2'(i);
            end
        end
    end

    // Counters, selection and shadow registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh_q <= '0;
            slot_q    <= SLOT_ONES;
            frame_q   <= '0;
            sel_q     <= 2'd0;
            // NOTE: the shadow registers are reset too, so a reset mid-frame
            // drops back to the dash display instead of showing stale data.
            num_q     <= '0;
            valid_q   <= '0;
        end else begin
            // NOTE: all sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of order.
            if (slot_wrap) begin
                refresh_q <= '0;
                slot_q    <= slot_e'(slot_q + 2'd1);
            end else begin
                refresh_q <= refresh_q + REFRESH_W'(1);
            end

            // A load restarts the dwell but leaves the scan running; it also
            // takes priority over a dwell advance on the same edge.
            if (load) begin
                num_q   <= numbers;
                valid_q <= valid;
                sel_q   <= load_sel;
                frame_q <= '0;
            end else if (frame_wrap) begin
                if (frame_q == FRAME_LAST) begin
                    frame_q <= '0;
                    sel_q   <= next_sel;
                end else begin
                    frame_q <= frame_q + FRAME_W'(1);
                end
            end
        end
    end

    // Digit selection for the current slot.
    logic [GROUP_W-1:0] group;
    logic [3:0]         hundreds;
    logic [3:0]         tens;
    logic [3:0]         ones;
    logic [3:0]         digit;
    logic               blank;
    logic [6:0]         digit_seg;

    assign group    = group_of(num_q, sel_q);
    assign hundreds = group[11:8];
    assign tens     = group[7:4];
    assign ones     = group[3:0];

    always_comb begin
        digit = ones;
        blank = 1'b0;
        case (slot_q)
            SLOT_INDEX:    digit = {2'b00, sel_q} + 4'd1;
            SLOT_HUNDREDS: begin
                digit = hundreds;
                blank = (hundreds == 4'd0);
            end
            SLOT_TENS:     begin
                digit = tens;
                blank = (hundreds == 4'd0) && (tens == 4'd0);
            end
            SLOT_ONES:     digit = ones;
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .digit (digit),
        .blank (blank),
        .seg   (digit_seg)
    );

    // Registered outputs, one cycle behind the slot/selection/shadow state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg <= SEG_BLANK;
            an  <= 4'b1111;
            dp  <= 1'b1;
        end else begin
            an <= ~(4'b0001 << slot_q);
            if (valid_q == 4'd0) begin
                seg <= SEG_DASH;
                dp  <= 1'b1;
            end else begin
                seg <= digit_seg;
                dp  <= (slot_q != SLOT_INDEX);
            end
        end
    end

endmodule
